marcador_juego: RTL

Scoreboard stage downstream of the two-player memory-card game FSM. It samples that FSM's match flag `j` and player flag `m` on each evaluated card pair, keeps per-player scores and the active turn, and counts remaining pairs. It declares game over and the winner when every pair is claimed, and can optionally pass the turn on inactivity. Outputs feed the board display/LED logic.

---
 rtl/juego_pkg.sv | 15 +
 rtl/contador_sat.sv | 28 ++
 rtl/marcador_juego.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/juego_pkg.sv
// Shared types for the memory-card game: scoreboard FSM states and winner codes.
package juego_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } estado_marcador_t;

    localparam logic [1:0] GANA_NADIE = 2'b00;
    localparam logic [1:0] GANA_J0    = 2'b01;
    localparam logic [1:0] GANA_J1    = 2'b10;
    localparam logic [1:0] EMPATE     = 2'b11;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module contador_sat #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAXV = '1;

    function automatic logic [W-1:0] satInc(input logic [W-1:0] v);
        return (v == MAXV) ? v : v + W'(1);
    endfunction

    // Count register: clear has priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= satInc(q);
    end

endmodule

// File: rtl/marcador_juego.sv
// Two-player memory-card scoreboard: per-player scores, active turn, remaining
// pairs, game-over and winner. Optional inactivity turn-pass is enabled with
// the macro MARCADOR_TIMEOUT_EN; without it timeout_pulse is tied low.
module marcador_juego
    import juego_pkg::*;
#(
    parameter int PAIRS          = 8,
    parameter int SCORE_W        = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               play_valid,
    input  logic               j,
    input  logic               m,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               turn,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               timeout_pulse
);

    localparam int PW = $clog2(PAIRS + 1);
    localparam logic [SCORE_W-1:0] SMAX = '1;

    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
        return (v == SMAX) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [1:0] decide(input logic [SCORE_W-1:0] a,
                                          input logic [SCORE_W-1:0] b);
        if (a > b)      return GANA_J0;
        else if (a < b) return GANA_J1;
        else            return EMPATE;
    endfunction

    estado_marcador_t state, stateNext;
    logic [PW-1:0]      pairsLeft, pairsNext;
    logic               turnNext;
    logic [1:0]         winnerNext;
    logic               clrScores, inc0, inc1, accepted;
    logic [SCORE_W-1:0] s0Upd, s1Upd;

`ifdef MARCADOR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idleCnt, idleNext;
    logic          pulseNext;
`endif

    // Scores as they would stand after a match by the player on turn.
    assign s0Upd    = (turn == 1'b0) ? satInc(score0) : score0;
    assign s1Upd    = (turn == 1'b1) ? satInc(score1) : score1;
    assign accepted = (state == PLAY) && play_valid && (m == turn);

    // Next-state and control decode; start overrides any play event.
    always_comb begin
        stateNext  = state;
        turnNext   = turn;
        pairsNext  = pairsLeft;
        winnerNext = winner;
        clrScores  = 1'b0;
        inc0       = 1'b0;
        inc1       = 1'b0;
`ifdef MARCADOR_TIMEOUT_EN
        idleNext   = idleCnt;
        pulseNext  = 1'b0;
`endif
        if (start) begin
            stateNext  = PLAY;
            turnNext   = 1'b0;
            pairsNext  = PW'(PAIRS);
            winnerNext = GANA_NADIE;
            clrScores  = 1'b1;
`ifdef MARCADOR_TIMEOUT_EN
            idleNext   = '0;
`endif
        end else if (accepted) begin
`ifdef MARCADOR_TIMEOUT_EN
            idleNext = '0;
`endif
            if (j) begin
                inc0      = ~turn;
                inc1      = turn;
                pairsNext = pairsLeft - PW'(1);
                if (pairsLeft == PW'(1)) begin
                    stateNext  = DONE;
                    winnerNext = decide(s0Upd, s1Upd);
                end
            end else begin
                turnNext = ~turn;
            end
        end
`ifdef MARCADOR_TIMEOUT_EN
        else if (state == PLAY) begin
            if (idleCnt == TMAX) begin
                turnNext  = ~turn;
                pulseNext = 1'b1;
                idleNext  = '0;
            end else begin
                idleNext = idleCnt + TW'(1);
            end
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            turn      <= 1'b0;
            pairsLeft <= PW'(PAIRS);
            winner    <= GANA_NADIE;
            game_over <= 1'b0;
        end else begin
            state     <= stateNext;
            turn      <= turnNext;
            pairsLeft <= pairsNext;
            winner    <= winnerNext;
            game_over <= (stateNext == DONE);
        end
    end

`ifdef MARCADOR_TIMEOUT_EN
    // Inactivity counter and its one-cycle turn-pass pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idleCnt       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            idleCnt       <= idleNext;
            timeout_pulse <= pulseNext;
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

    contador_sat #(.W(SCORE_W)) uScore0 (
        .clk (clk),
        .rst (rst),
        .clr (clrScores),
        .en  (inc0),
        .q   (score0)
    );

    contador_sat #(.W(SCORE_W)) uScore1 (
        .clk (clk),
        .rst (rst),
        .clr (clrScores),
        .en  (inc1),
        .q   (score1)
    );

endmodule
